// File: rtl/screen_clearer.sv
// screen_clearer: executes clear-screen / clear-line commands by writing
// BLANK_CHAR to every affected text VRAM cell, one write per granted cycle.
// Optional feature macro: SCREEN_CLEAR_HOME_EN adds cursor_home / home_row
// outputs so the cursor logic can return the cursor to column 0.
module screen_clearer #(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30,
  parameter int          ADDR_W     = 12,
  parameter int          ROW_W      = 5,
  parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_start,
  input  logic              mode,
  input  logic [ROW_W-1:0]  line_index,
  input  logic              vram_ready,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  output logic              busy,
  output logic              done
`ifdef SCREEN_CLEAR_HOME_EN
  ,
  output logic              cursor_home,
  output logic [ROW_W-1:0]  home_row
`endif
);

  localparam logic [ADDR_W-1:0] COLS_A    = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LINE_SPAN = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS * ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state, state_next;
  logic              start_prev;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [ADDR_W-1:0] end_addr, end_next;
  logic              start_acc;
  logic              line_ok;
  logic [ADDR_W-1:0] row_base;

  // Row base is only needed at command acceptance, so one multiply suffices;
  // the per-cell walk afterwards is a plain increment.
  assign row_base  = ADDR_W'(line_index) * COLS_A;
  assign line_ok   = 32'(line_index) < ROWS;
  assign start_acc = clear_start & ~start_prev;
  assign vram_addr = addr_q;

`ifdef SCREEN_CLEAR_HOME_EN
  logic [ROW_W-1:0] home_q, home_next;
  assign home_row    = home_q;
  assign cursor_home = done;
`endif

  // State, walk address, end address and start edge-detect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      start_prev <= 1'b0;
      addr_q     <= '0;
      end_addr   <= '0;
`ifdef SCREEN_CLEAR_HOME_EN
      home_q     <= '0;
`endif
    end else begin
      state      <= state_next;
      start_prev <= clear_start;
      addr_q     <= addr_next;
      end_addr   <= end_next;
`ifdef SCREEN_CLEAR_HOME_EN
      home_q     <= home_next;
`endif
    end
  end

  // Next-state, walk control and write/status outputs
  always_comb begin
    state_next = state;
    addr_next  = addr_q;
    end_next   = end_addr;
    vram_we    = 1'b0;
    vram_wdata = 8'h00;
    busy       = 1'b0;
    done       = 1'b0;
`ifdef SCREEN_CLEAR_HOME_EN
    home_next  = home_q;
`endif
    unique case (state)
      ST_IDLE: begin
        // Edges seen in CLEAR/DONE are simply lost: only IDLE looks at start_acc.
        if (start_acc) begin
          if (!mode) begin
            addr_next  = '0;
            end_next   = LAST_ADDR;
            state_next = ST_CLEAR;
`ifdef SCREEN_CLEAR_HOME_EN
            home_next  = '0;
`endif
          end else if (line_ok) begin
            addr_next  = row_base;
            end_next   = row_base + LINE_SPAN;
            state_next = ST_CLEAR;
`ifdef SCREEN_CLEAR_HOME_EN
            home_next  = line_index;
`endif
          end else begin
            // Out-of-range line: nothing to write, report completion at once.
            state_next = ST_DONE;
`ifdef SCREEN_CLEAR_HOME_EN
            home_next  = '0;
`endif
          end
        end
      end
      ST_CLEAR: begin
        vram_we    = 1'b1;
        vram_wdata = BLANK_CHAR;
        busy       = 1'b1;
        // Without a grant the request and address simply hold.
        if (vram_ready) begin
          if (addr_q == end_addr) state_next = ST_DONE;
          else                    addr_next  = addr_q + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        busy       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_screen_clearer.sv
// Testbench for screen_clearer: randomized clear commands and grant patterns
// checked against a transaction-level model (expected address list per
// command, one done pulse after the last granted write).
module tb_screen_clearer;

  localparam int COLS   = 80;
  localparam int ROWS   = 30;
  localparam int ADDR_W = 12;
  localparam int ROW_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear_start;
  logic              mode;
  logic [ROW_W-1:0]  line_index;
  logic              vram_ready;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_wdata;
  logic              busy;
  logic              done;
`ifdef SCREEN_CLEAR_HOME_EN
  logic              cursor_home;
  logic [ROW_W-1:0]  home_row;
`endif

  int n_checks = 0;
  int n_errors = 0;

  screen_clearer #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .ROW_W(ROW_W), .BLANK_CHAR(8'h20)
  ) dut (
    .clk(clk), .rst(rst), .clear_start(clear_start), .mode(mode),
    .line_index(line_index), .vram_ready(vram_ready), .vram_we(vram_we),
    .vram_addr(vram_addr), .vram_wdata(vram_wdata), .busy(busy), .done(done)
`ifdef SCREEN_CLEAR_HOME_EN
    , .cursor_home(cursor_home), .home_row(home_row)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_we"},   32'(vram_we), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_wd"},   32'(vram_wdata), 0);
  endtask

  function automatic logic pick_ready(input int rmode, input int c);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return (c % 3) == 1;
    return 1'($urandom % 2);
  endfunction

  // Issue one command and follow it to completion. rmode: 0 grant always,
  // 1 grant pattern 1,0,0,..., 2 random grant. edge_at_done raises
  // clear_start during the done cycle, which must not start a new clear.
  task automatic do_clear(input bit m, input int li, input int rmode, input bit edge_at_done);
    int exp_q[$];
    int nw;
    int limit;
    int c;
    bit seen_done;
    int exp_home;
    exp_q = {};
    if (!m) begin
      for (int a = 0; a < COLS * ROWS; a++) exp_q.push_back(a);
      exp_home = 0;
    end else if (li < ROWS) begin
      for (int a = li * COLS; a < (li + 1) * COLS; a++) exp_q.push_back(a);
      exp_home = li;
    end else begin
      exp_home = 0;
    end
    nw = exp_q.size();
    limit = 4 * nw + 20;
    seen_done = 0;

    @(posedge clk); #1;
    clear_start = 1'b1; mode = m; line_index = ROW_W'(li); vram_ready = 1'b0;
    @(posedge clk); #1;
    // Changes after acceptance must have no effect.
    mode = 1'($urandom); line_index = ROW_W'($urandom);
    c = 1;
    while (1) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      vram_ready = pick_ready(rmode, c);
      if (c == 2)  clear_start = 1'b0;
      if (c == 40) clear_start = 1'b1;
      if (c == 42) clear_start = 1'b0;
      @(negedge clk);
      if (c == 1) check("first_we", 32'(vram_we), 32'(nw > 0));
      check("busy", 32'(busy), 32'(vram_we | done));
      check("wdata", 32'(vram_wdata), vram_we ? 32'h20 : 32'h0);
      if (vram_we && vram_ready) begin
        if (exp_q.size() == 0) check("extra_wr", 32'(vram_addr), 32'hFFFF_FFFF);
        else                   check("addr", 32'(vram_addr), 32'(exp_q.pop_front()));
      end
      if (done) begin
        seen_done = 1;
        check("left", 32'(exp_q.size()), 0);
        check("done_we", 32'(vram_we), 0);
        if (rmode == 0) check("latency", 32'(c), 32'(nw + 1));
`ifdef SCREEN_CLEAR_HOME_EN
        check("home_pulse", 32'(cursor_home), 1);
        check("home_row", 32'(home_row), 32'(exp_home));
`endif
        if (edge_at_done) clear_start = 1'b1;
        break;
      end
`ifdef SCREEN_CLEAR_HOME_EN
      check("home_idle", 32'(cursor_home), 0);
`endif
      if (c >= limit) begin
        check("timeout", 1, 0);
        break;
      end
      c++;
    end
    if (!seen_done) check("no_done", 0, 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      vram_ready = 1'($urandom);
      @(negedge clk);
      check_idle("after");
    end
    @(posedge clk); #1;
    clear_start = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; clear_start = 1'b0; mode = 1'b0; line_index = '0; vram_ready = 1'b1;

    // Reset, then idle
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_idle("rst");
      check("rst_addr", 32'(vram_addr), 0);
    end
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle("idle");
      check("idle_addr", 32'(vram_addr), 0);
      @(posedge clk); #1;
    end

    do_clear(1'b0, 0, 0, 1'b0);   // full screen, grant always
    do_clear(1'b1, 5, 1, 1'b1);   // line 5, 1,0,0 grant, edge at done
    do_clear(1'b1, 29, 0, 1'b0);  // last line
    do_clear(1'b1, 31, 0, 1'b1);  // out of range
    do_clear(1'b1, 30, 2, 1'b0);  // first out-of-range index

    // Abort a full clear at its 100th write
    @(posedge clk); #1;
    clear_start = 1'b1; mode = 1'b0; vram_ready = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 100; c++) begin
      @(negedge clk);
      if (vram_we && vram_ready) cnt++;
      if (cnt < 100) begin
        @(posedge clk); #1;
      end
    end
    check("abort_at", 32'(vram_addr), 99);
    rst = 1'b1;
    @(negedge clk);
    check_idle("abort");
    check("abort_addr", 32'(vram_addr), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_idle("abort2");

    do_clear(1'b0, 0, 2, 1'b0);   // fresh full clear, random grant

    for (int i = 0; i < 6; i++)
      do_clear(1'b1, int'($urandom_range(0, 31)), int'($urandom_range(0, 2)), 1'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
